// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock.
// Signed or unsigned per operation, truncating semantics, divide-by-zero fast path.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

    // Next-state logic: load magnitudes, iterate restoring steps, then fix signs.
    always_comb begin
        state_d       = state_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_quo_d = dvd_neg ^ dvs_neg;
                    neg_rem_d = dvd_neg;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dvsr_d    = dvs_neg ? -divisor : divisor;
                    if (divisor == '0) begin
                        // Keep the raw dividend; it is returned as the remainder.
                        dbz_d   = 1'b1;
                        quo_d   = dividend;
                        state_d = S_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = dvd_neg ? -dividend : dividend;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (diff[WIDTH]) begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0]
                                            : rem_q[WIDTH-1:0];
                end
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for 32-bit and 8-bit seq_divider instances.
// Stimulus pushes expected results; per-instance monitors pop on done.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        start32 = 1'b0;
    logic        sgn32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    logic        start8 = 1'b0;
    logic        sgn8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    exp_t sb32[$];
    exp_t sb8[$];

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input logic [31:0] q,
                           input logic [31:0] r, input logic z,
                           input logic b);
        check({e.name, " quotient"}, q, e.q);
        check({e.name, " remainder"}, r, e.r);
        check({e.name, " div_by_zero"}, 32'(z), 32'(e.z));
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, " busy in done"}, 32'(b), 32'd0);
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst && done32) begin
            if (sb32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut32 unexpected done: got 1 expected 0");
            end else begin
                compare(sb32.pop_front(), q32, r32, dbz32, busy32);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut8 unexpected done: got 1 expected 0");
            end else begin
                compare(sb8.pop_front(), {24'd0, q8}, {24'd0, r8}, dbz8, busy8);
            end
        end
    end

    task automatic issue32(input string n, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r,
                           input logic z, input int lat, output int e0);
        exp_t e;
        @(negedge clk);
        sgn32   = s;
        a32     = a;
        b32     = b;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        e0      = cyc;
        start32 = 1'b0;
        e.q = q; e.r = r; e.z = z; e.cyc = e0 + lat; e.name = n;
        sb32.push_back(e);
    endtask

    task automatic issue8(input string n, input logic s,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r,
                          input int lat);
        exp_t e;
        @(negedge clk);
        sgn8   = s;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        e.q = {24'd0, q}; e.r = {24'd0, r}; e.z = 1'b0;
        e.cyc = cyc + lat; e.name = n;
        sb8.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy32 || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy32 || busy8) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout: got busy expected idle");
        end
    endtask

    initial begin
        int   e0;
        exp_t e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy32), 32'd0);
        check("reset done", 32'(done32), 32'd0);
        check("reset quotient", q32, 32'd0);
        check("reset remainder", r32, 32'd0);
        check("reset dbz", 32'(dbz32), 32'd0);

        issue32("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, e0);
        @(negedge clk);
        check("busy after start", 32'(busy32), 32'd1);
        wait_idle();
        issue32("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, e0);
        wait_idle();
        issue32("u FFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'd2,
                32'h7FFFFFFC, 32'd1, 1'b0, 33, e0);
        wait_idle();
        issue32("s MIN/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0, 1'b0, 33, e0);
        wait_idle();
        issue32("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1,
                32'hFFFFFFFF, 32'd0, 1'b0, 33, e0);
        wait_idle();
        issue32("s -8/-3", 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD,
                32'd2, 32'hFFFFFFFE, 1'b0, 33, e0);
        wait_idle();
        issue32("u 1234/0", 1'b0, 32'h1234, 32'd0,
                32'hFFFFFFFF, 32'h1234, 1'b1, 1, e0);
        wait_idle();
        issue32("u after dbz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, e0);
        wait_idle();
        issue32("s -7/0", 1'b1, 32'hFFFFFFF9, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1, e0);
        wait_idle();

        // start held through busy with new operands: second op begins
        // at the edge closing the first op's done cycle.
        @(negedge clk);
        sgn32   = 1'b0;
        a32     = 32'd1000;
        b32     = 32'd10;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        e.q = 32'd100; e.r = 32'd0; e.z = 1'b0; e.cyc = e0 + 33;
        e.name = "b2b first";
        sb32.push_back(e);
        e.q = 32'hFFFFFFFD; e.r = 32'd1; e.z = 1'b0; e.cyc = e0 + 67;
        e.name = "b2b second";
        sb32.push_back(e);
        sgn32 = 1'b1;
        a32   = 32'd7;
        b32   = 32'hFFFFFFFE;
        repeat (34) @(posedge clk);
        #1 start32 = 1'b0;
        wait_idle();

        // Reset mid-operation: outputs clear and no done pulse follows.
        issue32("aborted", 1'b0, 32'd500, 32'd3, 32'd0, 32'd0, 1'b0, 33, e0);
        void'(sb32.pop_back());
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy32), 32'd0);
        check("abort done", 32'(done32), 32'd0);
        check("abort quotient", q32, 32'd0);
        check("abort remainder", r32, 32'd0);
        check("abort dbz", 32'(dbz32), 32'd0);
        repeat (40) @(negedge clk);

        issue8("w8 s -128/3", 1'b1, 8'h80, 8'h03, 8'hD6, 8'hFE, 9);
        wait_idle();
        issue8("w8 u 200/7", 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 9);
        wait_idle();

        begin
            int n;
            n = 0;
            while ((sb32.size() != 0 || sb8.size() != 0) && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (sb32.size() != 0 || sb8.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard drain: got %0d pending expected 0",
                         sb32.size() + sb8.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider producing one quotient bit per clock, in signed or unsigned mode, selected per operation. It replaces the fixed 32-bit unsigned shift-subtract divider in the CPU execute stage and serves DIV/DIVU/REM/REMU. It adds a start/busy/done handshake, synchronous reset, a divide-by-zero fast path and truncating signed semantics.

## Interface
- WIDTH, 32: operand and result width in bits, ≥ 2.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  registered; set when the last completed operation had divisor 0.

## Operation
- States: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE, start=1:
  - Capture is_signed and the operand signs.
  - Load the unsigned magnitude of each operand. In signed mode the value is negated if its MSB is set; in unsigned mode it is taken as-is.
  - Clear the partial remainder (WIDTH+1 bits) and the bit counter.
- IDLE, start=1, divisor==0 (fast path): skip CALC and go to FIX with dbz pending.
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1; quo MSB enters rem LSB.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quo LSB=1; otherwise keep the shifted rem and set quo LSB=0.
  - Increment the counter. After WIDTH steps go to FIX.
- FIX:
  - Negate the quotient iff signed mode and the operand signs differ.
  - Negate the remainder iff signed mode and the dividend is negative (the remainder takes the dividend's sign).
  - Register quotient, remainder and div_by_zero. Assert done. Go to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend as given, div_by_zero=1. This applies in both modes.
- Signed overflow (MIN / −1): needs no special path. The magnitude 2^(WIDTH−1) fits unsigned; negation wraps, so quotient = MIN and remainder = 0.
- start while busy is ignored; operands are not resampled.
- quotient, remainder and div_by_zero hold their values until the next FIX.

## Timing
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0.
- Cycle numbering: start accepted at edge E0.
- Normal operation:
  - busy is high from E0 to E(WIDTH+1).
  - done is high for exactly one cycle, between E(WIDTH+1) and E(WIDTH+2).
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: busy is high from E0 to E1, done pulses from E1 to E2, latency 1.
- done and busy=0 coincide. start may be asserted in the done cycle and is accepted at that edge (back-to-back operations, no bubble).
- rst=1 at any edge overrides everything: abort to IDLE, all outputs return to reset values, and no done pulse is produced for the aborted operation.
- start together with rst: rst wins and the request is dropped.

## Test plan
- WIDTH=32, unsigned, 100 / 7, start at E0 → busy for 33 cycles; done at E33 with quotient=14, remainder=2, div_by_zero=0.
- Signed −7 / 2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). The same operands unsigned → quotient 0x7FFFFFFC, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Then unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, dividend 0x1234 → done at E1, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1. A following valid divide clears div_by_zero.
- start held high with new operands during busy → the first result is unchanged, and the second operation begins exactly in the done cycle.
- rst pulsed at E10 of an operation → outputs zero from E11, no done pulse. A WIDTH=8 instance, signed −128 / 3 → quotient 0xD6 (−42), remainder 0xFE (−2), latency 9.
